// File: rtl/sensemi_axil_pkg.sv
// Shared types and constants for the sensemi AXI4-Lite register bridge.
package sensemi_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_EXEC,
    WR_RESP,
    RD_EXEC,
    RD_WAIT,
    RD_RESP
  } axil_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sensemi_axil_regs_bridge.sv
// AXI4-Lite slave that turns each write/read into a one-cycle strobe on the simple register bus.
// One transaction is in flight at a time; ties between reads and writes alternate.
module sensemi_axil_regs_bridge
  import sensemi_axil_pkg::*;
#(
  parameter  int AXI_ADDR_WIDTH = 13,
  parameter  int AXI_DATA_WIDTH = 32,
  parameter  int RD_LATENCY     = 1,
  localparam int ADDR_LSB       = AXI_DATA_WIDTH / 32 + 1,
  localparam int OFS_W          = AXI_ADDR_WIDTH - ADDR_LSB
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                  s_axi_awprot,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic                        reg_wren,
  output logic [OFS_W-1:0]            reg_wr_offset,
  output logic [AXI_DATA_WIDTH-1:0]   reg_wdata,
  output logic                        reg_rden,
  output logic [OFS_W-1:0]            reg_rd_offset,
  input  logic [AXI_DATA_WIDTH-1:0]   reg_rdata
);

  axil_state_t                r_state;
  axil_state_t                w_next;
  logic                       r_last_wr;
  logic [3:0]                 r_lat_cnt;
  logic                       r_bvalid;
  logic [1:0]                 r_bresp;
  logic                       r_rvalid;
  logic [1:0]                 r_rresp;
  logic [AXI_DATA_WIDTH-1:0]  r_rdata;
  logic                       r_wren;
  logic [OFS_W-1:0]           r_wr_offset;
  logic [AXI_DATA_WIDTH-1:0]  r_wdata;
  logic                       r_rden;
  logic [OFS_W-1:0]           r_rd_offset;
  logic                       w_wr_elig;
  logic                       w_rd_elig;
  logic                       w_grant_wr;
  logic                       w_grant_rd;
  logic                       w_strb_full;
  logic                       w_unused;

  // Byte-lane bits of the address and the protection fields carry no meaning here.
  assign w_unused = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0],
                      s_axi_awprot, s_axi_arprot};

  assign w_strb_full = (s_axi_wstrb == '1);

  // Readies are gated by reset so nothing is accepted while the bridge is being cleared.
  always_comb begin
    w_wr_elig  = s_axi_awvalid && s_axi_wvalid;
    w_rd_elig  = s_axi_arvalid;
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (s_axi_aresetn && (r_state == IDLE)) begin
      w_grant_wr = w_wr_elig && (!w_rd_elig || !r_last_wr);
      w_grant_rd = w_rd_elig && (!w_wr_elig ||  r_last_wr);
    end
  end

  assign s_axi_awready = w_grant_wr;
  assign s_axi_wready  = w_grant_wr;
  assign s_axi_arready = w_grant_rd;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_wr)      w_next = w_strb_full ? WR_EXEC : WR_RESP;
        else if (w_grant_rd) w_next = RD_EXEC;
      end
      WR_EXEC: w_next = WR_RESP;
      WR_RESP: if (s_axi_bready) w_next = IDLE;
      RD_EXEC: w_next = RD_WAIT;
      RD_WAIT: if (r_lat_cnt == 4'd0) w_next = RD_RESP;
      RD_RESP: if (s_axi_rready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_state     <= IDLE;
      r_last_wr   <= 1'b0;
      r_lat_cnt   <= 4'd0;
      r_bvalid    <= 1'b0;
      r_bresp     <= AXI_RESP_OKAY;
      r_rvalid    <= 1'b0;
      r_rresp     <= AXI_RESP_OKAY;
      r_rdata     <= '0;
      r_wren      <= 1'b0;
      r_wr_offset <= '0;
      r_wdata     <= '0;
      r_rden      <= 1'b0;
      r_rd_offset <= '0;
    end else begin
      r_state <= w_next;
      r_wren  <= 1'b0;
      r_rden  <= 1'b0;
      if (w_grant_wr) begin
        r_wr_offset <= s_axi_awaddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
        r_wdata     <= s_axi_wdata;
        r_last_wr   <= 1'b1;
        r_wren      <= w_strb_full;
        // Partial strobes are refused outright, so the error response goes out immediately.
        r_bvalid    <= !w_strb_full;
        r_bresp     <= w_strb_full ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
      if (w_grant_rd) begin
        r_rd_offset <= s_axi_araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
        r_rden      <= 1'b1;
        r_last_wr   <= 1'b0;
      end
      case (r_state)
        WR_EXEC: r_bvalid <= 1'b1;
        WR_RESP: if (s_axi_bready) r_bvalid <= 1'b0;
        RD_EXEC: r_lat_cnt <= 4'(RD_LATENCY - 1);
        RD_WAIT: begin
          if (r_lat_cnt == 4'd0) begin
            r_rdata  <= reg_rdata;
            r_rresp  <= AXI_RESP_OKAY;
            r_rvalid <= 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        RD_RESP: if (s_axi_rready) r_rvalid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign reg_wren      = r_wren;
  assign reg_wr_offset = r_wr_offset;
  assign reg_wdata     = r_wdata;
  assign reg_rden      = r_rden;
  assign reg_rd_offset = r_rd_offset;

endmodule

// File: tb/tb_sensemi_axil_regs_bridge.sv
// Bench for sensemi_axil_regs_bridge: two instances (read latency 1 and 4) share one stimulus
// stream and are compared each cycle against a transaction-level model of the bridge.
module tb_sensemi_axil_regs_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic [12:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        awready [2];
  logic        wready  [2];
  logic        arready [2];
  logic        bvalid  [2];
  logic        rvalid  [2];
  logic        wren    [2];
  logic        rden    [2];
  logic [1:0]  bresp   [2];
  logic [1:0]  rresp   [2];
  logic [31:0] rdata   [2];
  logic [31:0] regWdata[2];
  logic [31:0] regRdata[2];
  logic [10:0] wrOff   [2];
  logic [10:0] rdOff   [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sensemi_axil_regs_bridge #(.AXI_ADDR_WIDTH(13), .AXI_DATA_WIDTH(32), .RD_LATENCY(1)) dut0 (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready[0]),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready[0]),
    .s_axi_bresp(bresp[0]), .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready[0]),
    .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]), .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready),
    .reg_wren(wren[0]), .reg_wr_offset(wrOff[0]), .reg_wdata(regWdata[0]),
    .reg_rden(rden[0]), .reg_rd_offset(rdOff[0]), .reg_rdata(regRdata[0]));

  sensemi_axil_regs_bridge #(.AXI_ADDR_WIDTH(13), .AXI_DATA_WIDTH(32), .RD_LATENCY(4)) dut1 (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready[1]),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready[1]),
    .s_axi_bresp(bresp[1]), .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready[1]),
    .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]), .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready),
    .reg_wren(wren[1]), .reg_wr_offset(wrOff[1]), .reg_wdata(regWdata[1]),
    .reg_rden(rden[1]), .reg_rd_offset(rdOff[1]), .reg_rdata(regRdata[1]));

  // Register file contents seen by the bridge; word 0x7FF is pinned to a known value.
  function automatic logic [31:0] memVal(input logic [10:0] off);
    if (off == 11'h7FF) return 32'h1234_5678;
    return 32'h9E37_79B1 * {21'd0, off} + 32'h0000_1357;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Register file read pipeline: data is only meaningful exactly RD_LATENCY cycles after the
  // strobe, and random junk is presented on every other cycle.
  logic        pv [2][4];
  logic [31:0] pd [2][4];
  logic [31:0] junk;

  always @(posedge clk) begin
    junk <= $urandom;
    for (int k = 0; k < 2; k++) begin
      pv[k][0] <= rden[k];
      pd[k][0] <= memVal(rdOff[k]);
      for (int i = 1; i < 4; i++) begin
        pv[k][i] <= pv[k][i-1];
        pd[k][i] <= pd[k][i-1];
      end
    end
  end

  assign regRdata[0] = pv[0][0] ? pd[0][0] : junk;
  assign regRdata[1] = pv[1][3] ? pd[1][3] : junk;

  // Transaction-level model: kind 0 none, 1 good write, 2 refused write, 3 read;
  // age counts cycles since the handshake.
  int          mKind  [2];
  int          mAge   [2];
  bit          mLastWr[2];
  logic [10:0] mWrOff [2];
  logic [10:0] mRdOff [2];
  logic [31:0] mWdata [2];
  logic [31:0] mRdata [2];
  logic [1:0]  mBresp [2];
  bit          modelLive = 1'b0;

  function automatic bit grantWr(input int k);
    return rstn && mKind[k] == 0 && awvalid && wvalid && (!arvalid || !mLastWr[k]);
  endfunction

  function automatic bit grantRd(input int k);
    return rstn && mKind[k] == 0 && arvalid && (!(awvalid && wvalid) || mLastWr[k]);
  endfunction

  function automatic bit expBvalid(input int k);
    return (mKind[k] == 1 && mAge[k] >= 2) || mKind[k] == 2;
  endfunction

  function automatic bit expRvalid(input int k);
    return mKind[k] == 3 && mAge[k] >= 2 + lat(k);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        mKind[k] = 0; mAge[k] = 0; mLastWr[k] = 1'b0;
        mWrOff[k] = '0; mRdOff[k] = '0; mWdata[k] = '0; mRdata[k] = '0; mBresp[k] = 2'b00;
      end else if (mKind[k] == 0) begin
        if (grantWr(k)) begin
          mKind[k]   = (wstrb == 4'hF) ? 1 : 2;
          mAge[k]    = 1;
          mLastWr[k] = 1'b1;
          mWrOff[k]  = awaddr[12:2];
          mWdata[k]  = wdata;
          mBresp[k]  = (wstrb == 4'hF) ? 2'b00 : 2'b10;
        end else if (grantRd(k)) begin
          mKind[k]   = 3;
          mAge[k]    = 1;
          mLastWr[k] = 1'b0;
          mRdOff[k]  = araddr[12:2];
        end
      end else if ((expBvalid(k) && bready) || (expRvalid(k) && rready)) begin
        mKind[k] = 0;
      end else begin
        if (mKind[k] == 3 && mAge[k] == 1 + lat(k)) mRdata[k] = memVal(mRdOff[k]);
        mAge[k]++;
      end
    end
    if (!rstn) modelLive = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, every output of both instances against the model.
  always @(negedge clk) begin
    #1;
    if (modelLive) begin
      for (int k = 0; k < 2; k++) begin
        string p;
        p = $sformatf("dut%0d.", k);
        checkOutput({p, "awready"}, 32'(awready[k]), 32'(grantWr(k)));
        checkOutput({p, "wready"},  32'(wready[k]),  32'(grantWr(k)));
        checkOutput({p, "arready"}, 32'(arready[k]), 32'(grantRd(k)));
        checkOutput({p, "bvalid"},  32'(bvalid[k]),  32'(expBvalid(k)));
        checkOutput({p, "rvalid"},  32'(rvalid[k]),  32'(expRvalid(k)));
        checkOutput({p, "wren"},    32'(wren[k]),    32'(mKind[k] == 1 && mAge[k] == 1));
        checkOutput({p, "rden"},    32'(rden[k]),    32'(mKind[k] == 3 && mAge[k] == 1));
        checkOutput({p, "bresp"},   32'(bresp[k]),   32'(mBresp[k]));
        checkOutput({p, "rresp"},   32'(rresp[k]),   32'h0);
        checkOutput({p, "rdata"},   rdata[k],        mRdata[k]);
        checkOutput({p, "wr_offset"}, 32'(wrOff[k]), 32'(mWrOff[k]));
        checkOutput({p, "wdata"},   regWdata[k],     mWdata[k]);
        checkOutput({p, "rd_offset"}, 32'(rdOff[k]), 32'(mRdOff[k]));
      end
    end
  end

  task automatic applyStimulus(input bit aw, input bit w, input bit ar,
                               input logic [12:0] wa, input logic [12:0] ra,
                               input logic [31:0] d, input logic [3:0] s,
                               input bit br, input bit rr);
    @(negedge clk);
    awvalid = aw; wvalid = w; arvalid = ar;
    awaddr = wa; araddr = ra; wdata = d; wstrb = s;
    bready = br; rready = rr;
    awprot = 3'($urandom); arprot = 3'($urandom);
    #2;
  endtask

  task automatic idle(input bit br, input bit rr);
    applyStimulus(1'b0, 1'b0, 1'b0, 13'h0, 13'h0, 32'h0, 4'h0, br, rr);
  endtask

  initial begin
    int order[$];
    int cyc;
    rstn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;

    // Reset state, with requests pending that must not be accepted.
    applyStimulus(1'b1, 1'b1, 1'b1, 13'h0010, 13'h0010, 32'h1, 4'hF, 1'b0, 1'b0);
    checkOutput("reset awready", 32'(awready[0]), 32'h0);
    checkOutput("reset arready", 32'(arready[0]), 32'h0);
    checkOutput("reset bvalid",  32'(bvalid[0]),  32'h0);
    checkOutput("reset rvalid",  32'(rvalid[1]),  32'h0);
    checkOutput("reset wren",    32'(wren[0]),    32'h0);
    checkOutput("reset rdata",   rdata[0],        32'h0);
    idle(1'b0, 1'b0);
    rstn = 1'b1;

    // Full-strobe write.
    applyStimulus(1'b1, 1'b1, 1'b0, 13'h0010, 13'h0, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    checkOutput("wr awready", 32'(awready[0]), 32'h1);
    checkOutput("wr wready",  32'(wready[0]),  32'h1);
    idle(1'b0, 1'b0);
    checkOutput("wr wren T+1",   32'(wren[0]),  32'h1);
    checkOutput("wr offset T+1", 32'(wrOff[0]), 32'h004);
    checkOutput("wr wdata T+1",  regWdata[0],   32'hDEAD_BEEF);
    checkOutput("wr bvalid T+1", 32'(bvalid[0]), 32'h0);
    idle(1'b1, 1'b0);
    checkOutput("wr wren T+2",   32'(wren[0]),   32'h0);
    checkOutput("wr bvalid T+2", 32'(bvalid[0]), 32'h1);
    checkOutput("wr bresp T+2",  32'(bresp[0]),  32'h0);
    idle(1'b0, 1'b0);
    checkOutput("wr bvalid done", 32'(bvalid[0]), 32'h0);

    // Read of the top word with both latencies.
    applyStimulus(1'b0, 1'b0, 1'b1, 13'h0, 13'h1FFC, 32'h0, 4'h0, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      idle(1'b0, 1'b0);
      if (c == 1) begin
        checkOutput("rd rden lat1",   32'(rden[0]),  32'h1);
        checkOutput("rd rden lat4",   32'(rden[1]),  32'h1);
        checkOutput("rd offset",      32'(rdOff[0]), 32'h7FF);
      end
      checkOutput($sformatf("rd rvalid lat1 T+%0d", c), 32'(rvalid[0]), 32'(c >= 3));
      checkOutput($sformatf("rd rvalid lat4 T+%0d", c), 32'(rvalid[1]), 32'(c >= 6));
    end
    checkOutput("rd rdata lat1", rdata[0], 32'h1234_5678);
    checkOutput("rd rdata lat4", rdata[1], 32'h1234_5678);
    checkOutput("rd rresp lat4", 32'(rresp[1]), 32'h0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    checkOutput("rd rvalid done", 32'(rvalid[1]), 32'h0);

    // Partial strobe is refused.
    applyStimulus(1'b1, 1'b1, 1'b0, 13'h0024, 13'h0, 32'hCAFE_F00D, 4'h3, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    checkOutput("slverr wren",   32'(wren[0]),   32'h0);
    checkOutput("slverr bvalid", 32'(bvalid[0]), 32'h1);
    checkOutput("slverr bresp",  32'(bresp[0]),  32'h2);
    checkOutput("slverr offset", 32'(wrOff[0]),  32'h009);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);

    // Fresh reset, then simultaneous requests held: write, read, write.
    rstn = 1'b0;
    idle(1'b0, 1'b0);
    rstn = 1'b1;
    for (int c = 0; c < 40 && order.size() < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 13'h0100, 13'h0200, 32'h5555_AAAA, 4'hF, 1'b1, 1'b1);
      if (wren[0]) order.push_back(1);
      if (rden[0]) order.push_back(0);
    end
    if (order.size() < 3) checkOutput("grant order timeout", 32'(order.size()), 32'd3);
    else checkOutput("grant order W,R,W", 32'(order[0] * 4 + order[1] * 2 + order[2]), 32'd5);
    repeat (10) idle(1'b1, 1'b1);

    // AW without W is never accepted.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 13'h0300, 13'h0, 32'h0, 4'hF, 1'b1, 1'b1);
      checkOutput("aw alone awready", 32'(awready[0]), 32'h0);
    end
    idle(1'b0, 1'b0);

    // Stalled B channel blocks a waiting read until the B handshake.
    applyStimulus(1'b1, 1'b1, 1'b0, 13'h0104, 13'h0, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 13'h0, 13'h0208, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("bstall arready", 32'(arready[0]), 32'h0);
      if (c >= 2) checkOutput("bstall bvalid", 32'(bvalid[0]), 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 13'h0, 13'h0208, 32'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("bstall arready at B hs", 32'(arready[0]), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 13'h0, 13'h0208, 32'h0, 4'h0, 1'b0, 1'b1);
    checkOutput("arready after B hs", 32'(arready[0]), 32'h1);
    repeat (10) idle(1'b0, 1'b1);

    // Reset while the latency-4 instance sits in its wait phase.
    applyStimulus(1'b0, 1'b0, 1'b1, 13'h0, 13'h1FFC, 32'h0, 4'h0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    rstn = 1'b0;
    idle(1'b0, 1'b0);
    rstn = 1'b1;
    checkOutput("rst rvalid",    32'(rvalid[1]), 32'h0);
    checkOutput("rst rden",      32'(rden[1]),   32'h0);
    checkOutput("rst rd_offset", 32'(rdOff[1]),  32'h0);
    checkOutput("rst wr_offset", 32'(wrOff[1]),  32'h0);
    checkOutput("rst wdata",     regWdata[1],    32'h0);
    checkOutput("rst rdata",     rdata[0],       32'h0);
    for (int c = 0; c < 10; c++) begin
      idle(1'b0, 1'b1);
      checkOutput("dropped read rvalid", 32'(rvalid[1]), 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 13'h0, 13'h1FFC, 32'h0, 4'h0, 1'b0, 1'b0);
    cyc = 0;
    while (!rvalid[1] && cyc < 20) begin
      idle(1'b0, 1'b0);
      cyc++;
    end
    checkOutput("post-reset read latency", 32'(cyc), 32'd6);
    checkOutput("post-reset read rdata",   rdata[1], 32'h1234_5678);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);

    // Random traffic, including occasional resets.
    repeat (3000) begin
      applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                    13'($urandom), 13'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
      rstn = ($urandom_range(0, 199) != 0);
    end
    idle(1'b1, 1'b1);
    rstn = 1'b1;
    repeat (2) idle(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
